gshare_bp_param: RTL and testbench
==================================

// Module: gshare_bp_param
// PURPOSE
//  Parametrised gshare branch predictor for the fetch stage: PHT of saturating counters indexed
//  by PC^GHR, direct-mapped tagged BTB, speculative global history with restore on mispredict.
//  Sits between FE (predict) and AGEX (resolve/update). Raises flush to FE/DE on a mispredict.
//  Contains a table-clear FSM run after reset.
// PARAMETERS
//  DBITS      32  address/data width
//  INSTSIZE   4   instruction size in bytes; fall-through = pc+INSTSIZE
//  PHT_IDX_W  8   PHT index bits; PHT has 2**PHT_IDX_W entries
//  BTB_IDX_W  4   BTB index bits; tag = pc[DBITS-1:BTB_IDX_W+2]
//  GHR_W      8   global history bits; must be <= PHT_IDX_W
//  CTR_W      2   PHT counter width
//  CTR_INIT   1   counter value written during clear (weakly not-taken)
// PORTS
//  clk          in  1          clock
//  reset        in  1          asynchronous, active-low reset
//  fe_valid     in  1          FE presents a fetch PC this cycle
//  fe_pc        in  DBITS      fetch PC
//  pred_pc      out DBITS      predicted next PC; flush_pc when flush=1
//  pred_taken   out 1          prediction is BTB hit AND counter MSB=1
//  pred_ghr     out GHR_W      GHR used for this prediction; travels with the instruction
//  ready        out 1          0 while tables clear; FE must stall
//  upd_valid    in  1          AGEX resolves an instruction
//  upd_is_br    in  1          resolved instruction is a branch/jump
//  upd_pc       in  DBITS      PC of resolved instruction
//  upd_taken    in  1          actual direction
//  upd_target   in  DBITS      actual taken target
//  upd_pred_pc  in  DBITS      next PC that was predicted for it
//  upd_ghr      in  GHR_W      pred_ghr carried with it
//  flush        out 1          mispredict; FE redirects, DE squashes
//  flush_pc     out DBITS      correct next PC
//  br_cnt       out 32         resolved branches (saturates at all-ones)
//  mispred_cnt  out 32         flushes (saturates at all-ones)
// BEHAVIOUR
//  FSM: CLEAR -> RUN. Reset (async, reset=0): state=CLEAR, clr_idx=0, ghr=0, counters=0, ready=0.
//  CLEAR: each cycle writes PHT[clr_idx]=CTR_INIT and BTB valid[clr_idx mod 2**BTB_IDX_W]=0.
//   clr_idx increments. At clr_idx = max(2**PHT_IDX_W,2**BTB_IDX_W)-1 the state goes to RUN.
//   Next cycle ready=1. For defaults this is 256 clear cycles.
//  During CLEAR: pred_pc=fe_pc+INSTSIZE, pred_taken=0, flush=0, updates ignored.
//  Predict (combinational, RUN): pht_idx = fe_pc[PHT_IDX_W+1:2] ^ {zero-ext ghr};
//   hit = valid & tag match; pred_taken = hit & ctr[CTR_W-1].
//   pred_pc = pred_taken ? target : fe_pc+INSTSIZE; pred_ghr = ghr.
//  Resolve (combinational): next = upd_taken ? upd_target : upd_pc+INSTSIZE.
//   flush = ready & upd_valid & (next != upd_pred_pc); flush_pc = next.
//   When flush=1, pred_pc = flush_pc.
//  Table update (posedge, RUN, upd_valid & upd_is_br):
//   - PHT[upd_pc[PHT_IDX_W+1:2]^upd_ghr] +1 if taken, -1 if not taken.
//   - The counter saturates at 0 and 2**CTR_W-1.
//   - BTB written {tag,1,upd_target} only when upd_taken=1; not-taken leaves BTB untouched.
//  Read/write same entry in the same cycle: the prediction sees the old value (write lands at the edge).
//  GHR (posedge, RUN), priority order:
//   1. flush: ghr <= upd_is_br ? {upd_ghr[GHR_W-2:0],upd_taken} : upd_ghr.
//      Any concurrent FE shift is discarded.
//   2. fe_valid & hit: ghr <= {ghr[GHR_W-2:0],pred_taken} (speculative).
//   3. otherwise hold. A non-flushing update never modifies ghr.
//  Counters: br_cnt++ on upd_valid&upd_is_br in RUN; mispred_cnt++ on flush. Both saturate.
//  Async reset mid-operation: immediately returns to CLEAR/ready=0 and restarts the clear.
// TESTING
//  T1 reset release -> ready=0 for 256 cycles then 1; during clear fe_pc=0x100 gives pred_pc=0x104, flush=0.
//  T2 ghr=0; 2x upd(pc=0x100,taken,target=0x80,pred_pc=0x80,ghr=0) -> flush=0, ghr stays 0;
//     then fe_pc=0x100 -> pred_pc=0x80, pred_taken=1.
//  T3 5 taken updates (ghr 0) -> ctr=3; 1 not-taken -> ctr=2, still predicts 0x80; 2 more not-taken -> predicts 0x104.
//  T4 upd(pc=0x100,taken,target=0x80,pred_pc=0x104,ghr=0x05) with fe_valid hit same cycle
//     -> flush=1, flush_pc=pred_pc=0x80; next ghr=0x0B; mispred_cnt+1.
//  T5 train 0x100 taken->0x80; fe_pc=0x140 (same BTB index, different tag) -> pred_taken=0, pred_pc=0x144.
//  T6 reset=0 asserted mid-run with ghr=0xA5 -> ready=0, ghr=0, counters=0 immediately; T2 lookup after re-clear predicts 0x104.

Source files
------------

// File: rtl/gshare_bp_param_if.sv
// Fetch/resolve bus between the front end, AGEX and the gshare predictor.
// master = FE/AGEX side (drives fetch and resolve), slave = predictor.
interface gshare_bp_param_if #(
  parameter int DBITS = 32,
  parameter int GHR_W = 8
);
  logic             fe_valid;
  logic [DBITS-1:0] fe_pc;
  logic [DBITS-1:0] pred_pc;
  logic             pred_taken;
  logic [GHR_W-1:0] pred_ghr;
  logic             ready;
  logic             upd_valid;
  logic             upd_is_br;
  logic [DBITS-1:0] upd_pc;
  logic             upd_taken;
  logic [DBITS-1:0] upd_target;
  logic [DBITS-1:0] upd_pred_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             flush;
  logic [DBITS-1:0] flush_pc;
  logic [31:0]      br_cnt;
  logic [31:0]      mispred_cnt;

  modport master (
    output fe_valid, fe_pc, upd_valid, upd_is_br, upd_pc, upd_taken,
           upd_target, upd_pred_pc, upd_ghr,
    input  pred_pc, pred_taken, pred_ghr, ready, flush, flush_pc,
           br_cnt, mispred_cnt
  );

  modport slave (
    input  fe_valid, fe_pc, upd_valid, upd_is_br, upd_pc, upd_taken,
           upd_target, upd_pred_pc, upd_ghr,
    output pred_pc, pred_taken, pred_ghr, ready, flush, flush_pc,
           br_cnt, mispred_cnt
  );
endinterface

// File: rtl/gshare_bp_param.sv
// Gshare branch predictor: PHT of saturating counters indexed by PC^GHR,
// direct-mapped tagged BTB, speculative global history restored on flush.
// A clear sweep initialises both tables after every reset.
//
// state | meaning
// CLEAR | sweeping clr_idx over PHT/BTB, ready=0, updates ignored
// RUN   | predicting and training, ready=1
module gshare_bp_param #(
  parameter int DBITS     = 32,
  parameter int INSTSIZE  = 4,
  parameter int PHT_IDX_W = 8,
  parameter int BTB_IDX_W = 4,
  parameter int GHR_W     = 8,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = 1
) (
  input logic             clk,
  input logic             reset,
  gshare_bp_param_if.slave bus
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int CLR_W = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;
  localparam int TAG_W = DBITS - BTB_IDX_W - 2;
  localparam logic [CLR_W-1:0] CLR_LAST = '1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [CLR_W-1:0] clr_idx_q;
  logic             ready_q;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      br_cnt_q, mispred_cnt_q;

  logic [CTR_W-1:0] pht_q       [PHT_N];
  logic             btb_valid_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [DBITS-1:0] btb_tgt_q   [BTB_N];

  logic [PHT_IDX_W-1:0] fe_pht_idx, upd_pht_idx;
  logic [BTB_IDX_W-1:0] fe_btb_idx, upd_btb_idx;
  logic                 fe_hit, fe_taken, upd_br, flush;
  logic [DBITS-1:0]     upd_next;
  logic [CTR_W-1:0]     pht_cur, pht_d;

  assign fe_pht_idx  = bus.fe_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign fe_btb_idx  = bus.fe_pc[BTB_IDX_W+1:2];
  assign upd_pht_idx = bus.upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bus.upd_ghr);
  assign upd_btb_idx = bus.upd_pc[BTB_IDX_W+1:2];

  // Lookup uses pre-edge table contents, so a same-cycle write is not visible.
  assign fe_hit   = ready_q & btb_valid_q[fe_btb_idx] &
                    (btb_tag_q[fe_btb_idx] == bus.fe_pc[DBITS-1:BTB_IDX_W+2]);
  assign fe_taken = fe_hit & pht_q[fe_pht_idx][CTR_W-1];

  assign upd_next = bus.upd_taken ? bus.upd_target : bus.upd_pc + DBITS'(INSTSIZE);
  assign flush    = ready_q & bus.upd_valid & (upd_next != bus.upd_pred_pc);
  assign upd_br   = ready_q & bus.upd_valid & bus.upd_is_br;

  assign bus.pred_taken  = fe_taken;
  assign bus.pred_pc     = flush    ? upd_next :
                           fe_taken ? btb_tgt_q[fe_btb_idx] : bus.fe_pc + DBITS'(INSTSIZE);
  assign bus.pred_ghr    = ghr_q;
  assign bus.ready       = ready_q;
  assign bus.flush       = flush;
  assign bus.flush_pc    = upd_next;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

  // Next history: a flush restores from the resolved instruction and wins over FE speculation.
  always_comb begin
    ghr_d = ghr_q;
    if (flush)
      ghr_d = bus.upd_is_br ? {bus.upd_ghr[GHR_W-2:0], bus.upd_taken} : bus.upd_ghr;
    else if (bus.fe_valid & fe_hit)
      ghr_d = {ghr_q[GHR_W-2:0], fe_taken};
  end

  // Saturating counter step for the resolved branch.
  always_comb begin
    pht_cur = pht_q[upd_pht_idx];
    pht_d   = pht_cur;
    if (bus.upd_taken) begin
      if (pht_cur != CTR_MAX) pht_d = pht_cur + 1'b1;
    end else begin
      if (pht_cur != '0) pht_d = pht_cur - 1'b1;
    end
  end

  // Control FSM, history register and saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      ready_q       <= 1'b0;
      ghr_q         <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == CLR_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          ghr_q <= ghr_d;
          if (upd_br && (br_cnt_q != '1))      br_cnt_q      <= br_cnt_q + 1'b1;
          if (flush && (mispred_cnt_q != '1))  mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
      endcase
    end
  end

  // Table storage: clear sweep, then training from resolved branches.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      pht_q[clr_idx_q[PHT_IDX_W-1:0]]       <= CTR_W'(CTR_INIT);
      btb_valid_q[clr_idx_q[BTB_IDX_W-1:0]] <= 1'b0;
    end else if (upd_br) begin
      pht_q[upd_pht_idx] <= pht_d;
      if (bus.upd_taken) begin
        btb_valid_q[upd_btb_idx] <= 1'b1;
        btb_tag_q[upd_btb_idx]   <= bus.upd_pc[DBITS-1:BTB_IDX_W+2];
        btb_tgt_q[upd_btb_idx]   <= bus.upd_target;
      end
    end
  end
endmodule

// File: tb/tb_gshare_bp_param.sv
// Bench for gshare_bp_param: directed scenarios plus randomized traffic
// checked against a table-level reference model.
module tb_gshare_bp_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gshare_bp_param_if #(.DBITS(32), .GHR_W(8)) bus ();

  gshare_bp_param #(
    .DBITS(32), .INSTSIZE(4), .PHT_IDX_W(8), .BTB_IDX_W(4),
    .GHR_W(8), .CTR_W(2), .CTR_INIT(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_pht [256];
  bit          m_bv  [16];
  logic [31:0] m_btag[16];
  logic [31:0] m_btgt[16];
  int          m_ghr;
  bit          m_ready;
  int          m_clr;
  int          m_br, m_mis;

  task automatic idle();
    bus.fe_valid = 0; bus.fe_pc = 0; bus.upd_valid = 0; bus.upd_is_br = 0;
    bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0; bus.upd_pred_pc = 0;
    bus.upd_ghr = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input logic [31:0] ppc, input logic [7:0] g, input bit br);
    bus.upd_valid = 1; bus.upd_is_br = br; bus.upd_pc = pc; bus.upd_taken = tk;
    bus.upd_target = tgt; bus.upd_pred_pc = ppc; bus.upd_ghr = g;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 0; #2; reset = 1;
    m_ready = 0; m_clr = 0; m_ghr = 0; m_br = 0; m_mis = 0;
  endtask

  task automatic test_reset();
    int n;
    bit flush_seen;
    idle();
    apply_reset();
    bus.fe_pc = 32'h100;
    upd(32'h100, 1, 32'h80, 32'h104, 8'h00, 1);
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready got %0h exp 0", bus.ready); end
    n_cmp++; if (bus.pred_pc !== 32'h104) begin n_bad++; $display("FAIL clr_pred_pc got %0h exp 104", bus.pred_pc); end
    n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL clr_pred_taken got %0h exp 0", bus.pred_taken); end
    n = 0; flush_seen = 0;
    while (!bus.ready && n < 400) begin
      if (bus.flush !== 1'b0) flush_seen = 1;
      tick(); n++;
    end
    idle(); #1;
    n_cmp++; if (flush_seen) begin n_bad++; $display("FAIL clr_flush got 1 exp 0"); end
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL clr_cycles got %0d exp 256", n); end
    n_cmp++; if (bus.br_cnt !== 32'd0) begin n_bad++; $display("FAIL clr_br_cnt got %0d exp 0", bus.br_cnt); end
    n_cmp++; if (bus.pred_ghr !== 8'h00) begin n_bad++; $display("FAIL clr_ghr got %0h exp 0", bus.pred_ghr); end
  endtask

  task automatic test_train();
    for (int i = 0; i < 2; i++) begin
      upd(32'h100, 1, 32'h80, 32'h80, 8'h00, 1); #1;
      n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL train_flush got %0h exp 0", bus.flush); end
      tick();
    end
    idle(); bus.fe_pc = 32'h100; #1;
    n_cmp++; if (bus.pred_ghr !== 8'h00) begin n_bad++; $display("FAIL train_ghr got %0h exp 0", bus.pred_ghr); end
    n_cmp++; if (bus.pred_pc !== 32'h80) begin n_bad++; $display("FAIL train_pred_pc got %0h exp 80", bus.pred_pc); end
    n_cmp++; if (bus.pred_taken !== 1'b1) begin n_bad++; $display("FAIL train_taken got %0h exp 1", bus.pred_taken); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin upd(32'h100, 1, 32'h80, 32'h80, 8'h00, 1); tick(); end
    upd(32'h100, 0, 32'hDEAD0000, 32'h104, 8'h00, 1); tick();
    idle(); bus.fe_pc = 32'h100; #1;
    n_cmp++; if (bus.pred_pc !== 32'h80) begin n_bad++; $display("FAIL sat_weak_pc got %0h exp 80", bus.pred_pc); end
    n_cmp++; if (bus.pred_taken !== 1'b1) begin n_bad++; $display("FAIL sat_weak_taken got %0h exp 1", bus.pred_taken); end
    for (int i = 0; i < 2; i++) begin upd(32'h100, 0, 32'h0, 32'h104, 8'h00, 1); tick(); end
    idle(); bus.fe_pc = 32'h100; #1;
    n_cmp++; if (bus.pred_pc !== 32'h104) begin n_bad++; $display("FAIL sat_nt_pc got %0h exp 104", bus.pred_pc); end
    n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL sat_nt_taken got %0h exp 0", bus.pred_taken); end
    n_cmp++; if (bus.br_cnt !== 32'd10) begin n_bad++; $display("FAIL sat_br_cnt got %0d exp 10", bus.br_cnt); end
    n_cmp++; if (bus.mispred_cnt !== 32'd0) begin n_bad++; $display("FAIL sat_mis_cnt got %0d exp 0", bus.mispred_cnt); end
  endtask

  task automatic test_flush();
    bus.fe_valid = 1; bus.fe_pc = 32'h100;
    upd(32'h100, 1, 32'h80, 32'h104, 8'h05, 1); #1;
    n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL fl_flush got %0h exp 1", bus.flush); end
    n_cmp++; if (bus.flush_pc !== 32'h80) begin n_bad++; $display("FAIL fl_flush_pc got %0h exp 80", bus.flush_pc); end
    n_cmp++; if (bus.pred_pc !== 32'h80) begin n_bad++; $display("FAIL fl_pred_pc got %0h exp 80", bus.pred_pc); end
    tick(); idle(); #1;
    n_cmp++; if (bus.pred_ghr !== 8'h0B) begin n_bad++; $display("FAIL fl_ghr got %0h exp 0B", bus.pred_ghr); end
    n_cmp++; if (bus.mispred_cnt !== 32'd1) begin n_bad++; $display("FAIL fl_mis_cnt got %0d exp 1", bus.mispred_cnt); end
    n_cmp++; if (bus.br_cnt !== 32'd11) begin n_bad++; $display("FAIL fl_br_cnt got %0d exp 11", bus.br_cnt); end
  endtask

  task automatic test_tag_miss();
    idle(); bus.fe_pc = 32'h140; #1;
    n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL tag_taken got %0h exp 0", bus.pred_taken); end
    n_cmp++; if (bus.pred_pc !== 32'h144) begin n_bad++; $display("FAIL tag_pred_pc got %0h exp 144", bus.pred_pc); end
  endtask

  task automatic test_async_reset();
    int n;
    upd(32'h200, 0, 32'h0, 32'h0, 8'hA5, 0); tick();
    idle(); #1;
    n_cmp++; if (bus.pred_ghr !== 8'hA5) begin n_bad++; $display("FAIL ar_pre_ghr got %0h exp A5", bus.pred_ghr); end
    @(negedge clk); #2; reset = 0; #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL ar_ready got %0h exp 0", bus.ready); end
    n_cmp++; if (bus.pred_ghr !== 8'h00) begin n_bad++; $display("FAIL ar_ghr got %0h exp 0", bus.pred_ghr); end
    n_cmp++; if (bus.br_cnt !== 32'd0) begin n_bad++; $display("FAIL ar_br_cnt got %0d exp 0", bus.br_cnt); end
    n_cmp++; if (bus.mispred_cnt !== 32'd0) begin n_bad++; $display("FAIL ar_mis_cnt got %0d exp 0", bus.mispred_cnt); end
    #1; reset = 1;
    n = 0;
    while (!bus.ready && n < 400) begin tick(); n++; end
    n_cmp++; if (n != 256) begin n_bad++; $display("FAIL ar_clr_cycles got %0d exp 256", n); end
    bus.fe_pc = 32'h100; #1;
    n_cmp++; if (bus.pred_pc !== 32'h104) begin n_bad++; $display("FAIL ar_pred_pc got %0h exp 104", bus.pred_pc); end
    n_cmp++; if (bus.pred_taken !== 1'b0) begin n_bad++; $display("FAIL ar_taken got %0h exp 0", bus.pred_taken); end
  endtask

  task automatic test_random();
    logic [31:0] fpc, upc, utgt, uppc, nxt, exp_pc;
    logic [7:0]  ughr;
    bit fv, uv, ubr, utk, hit, tk, fl;
    int fidx, fb, ui, ub;
    idle();
    apply_reset();
    for (int cyc = 0; cyc < 900; cyc++) begin
      fv   = ($urandom_range(0, 1) == 1);
      fpc  = 32'h100 + 4 * $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
      uv   = ($urandom_range(0, 9) < 6);
      ubr  = ($urandom_range(0, 9) < 8);
      utk  = ($urandom_range(0, 1) == 1);
      upc  = 32'h100 + 4 * $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
      utgt = 32'h80 + 4 * $urandom_range(0, 7);
      ughr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(m_ghr);
      nxt  = utk ? utgt : upc + 4;
      case ($urandom_range(0, 9))
        0, 1:    uppc = upc + 4;
        2:       uppc = utgt;
        default: uppc = nxt;
      endcase
      bus.fe_valid = fv; bus.fe_pc = fpc; bus.upd_valid = uv; bus.upd_is_br = ubr;
      bus.upd_pc = upc; bus.upd_taken = utk; bus.upd_target = utgt;
      bus.upd_pred_pc = uppc; bus.upd_ghr = ughr;
      #1;
      fidx = int'((fpc >> 2) & 32'hFF) ^ m_ghr;
      fb   = int'((fpc >> 2) & 32'hF);
      hit  = m_ready && m_bv[fb] && (m_btag[fb] == (fpc >> 6));
      tk   = hit && (m_pht[fidx] >= 2);
      fl   = m_ready && uv && (nxt != uppc);
      exp_pc = fl ? nxt : (tk ? m_btgt[fb] : fpc + 4);
      n_cmp++; if (bus.ready !== m_ready) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %0h exp %0h", cyc, bus.ready, m_ready); end
      n_cmp++; if (bus.pred_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pred_pc cyc %0d got %0h exp %0h", cyc, bus.pred_pc, exp_pc); end
      n_cmp++; if (bus.pred_taken !== tk) begin n_bad++; $display("FAIL rnd_taken cyc %0d got %0h exp %0h", cyc, bus.pred_taken, tk); end
      n_cmp++; if (bus.pred_ghr !== 8'(m_ghr)) begin n_bad++; $display("FAIL rnd_ghr cyc %0d got %0h exp %0h", cyc, bus.pred_ghr, m_ghr); end
      n_cmp++; if (bus.flush !== fl) begin n_bad++; $display("FAIL rnd_flush cyc %0d got %0h exp %0h", cyc, bus.flush, fl); end
      n_cmp++; if (bus.flush_pc !== nxt) begin n_bad++; $display("FAIL rnd_flush_pc cyc %0d got %0h exp %0h", cyc, bus.flush_pc, nxt); end
      n_cmp++; if (bus.br_cnt !== 32'(m_br)) begin n_bad++; $display("FAIL rnd_br_cnt cyc %0d got %0d exp %0d", cyc, bus.br_cnt, m_br); end
      n_cmp++; if (bus.mispred_cnt !== 32'(m_mis)) begin n_bad++; $display("FAIL rnd_mis_cnt cyc %0d got %0d exp %0d", cyc, bus.mispred_cnt, m_mis); end
      // advance the model by one clock edge
      if (!m_ready) begin
        m_clr++;
        if (m_clr == 256) begin
          m_ready = 1;
          for (int i = 0; i < 256; i++) m_pht[i] = 1;
          for (int i = 0; i < 16; i++) m_bv[i] = 0;
        end
      end else begin
        if (uv && ubr) begin
          ui = int'((upc >> 2) & 32'hFF) ^ int'(ughr);
          ub = int'((upc >> 2) & 32'hF);
          if (utk) begin
            if (m_pht[ui] < 3) m_pht[ui]++;
            m_bv[ub] = 1; m_btag[ub] = upc >> 6; m_btgt[ub] = utgt;
          end else if (m_pht[ui] > 0) m_pht[ui]--;
          m_br++;
        end
        if (fl) begin
          m_mis++;
          m_ghr = ubr ? ((int'(ughr) * 2 + int'(utk)) % 256) : int'(ughr);
        end else if (fv && hit) begin
          m_ghr = (m_ghr * 2 + int'(tk)) % 256;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_train();
    test_saturate();
    test_flush();
    test_tag_miss();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
